ex_stage: RTL and testbench

Execute stage of the 5-stage 64-bit RISC-V pipeline. It consumes the ID/EX register outputs and computes the ALU result, branch decision and branch target. It runs an iterative 64-cycle multiplier for MUL and registers everything into the EX/MEM pipeline register that feeds the MEM stage. While a multiply is in flight it drives `stall` to hold IF/ID and ID/EX, and it inserts bubbles into EX/MEM.

---
 rtl/ex_pkg.sv | 57 +++++
 rtl/ex_stage_mul.sv | 79 +++++++
 rtl/ex_stage.sv | 119 +++++++++++
 tb/tb_ex_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared encodings and helpers for the execute stage
package ex_pkg;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ZERO  = 2'b11;

  localparam int MUL_CYCLES = 64;
  localparam int MUL_CNT_W  = $clog2(MUL_CYCLES);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_SRL  = 4'd4,
    ALU_SRA  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_ZERO = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // funct3 here is {funct7[5], funct3}; SUB with an immediate source is ADDI.
  function automatic alu_op_e alu_decode(input logic [1:0] aluop,
                                         input logic [3:0] funct3,
                                         input logic       alusrc);
    alu_op_e op;
    op = ALU_ZERO;
    case (aluop)
      ALUOP_MEM: op = ALU_ADD;
      ALUOP_BR:  op = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          4'b0000: op = ALU_ADD;
          4'b1000: op = alusrc ? ALU_ADD : ALU_SUB;
          4'b0001: op = ALU_SLL;
          4'b0100: op = ALU_XOR;
          4'b0101: op = ALU_SRL;
          4'b1101: op = ALU_SRA;
          4'b0110: op = ALU_OR;
          4'b0111: op = ALU_AND;
          default: op = ALU_ZERO;
        endcase
      end
      default: op = ALU_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_stage_mul.sv
// rtl/ex_stage_mul.sv - iterative radix-2 shift-add multiplier, low 64 product bits
module mul_iter
  import ex_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        abort_i,
  input  logic        start_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic        idle_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] product_o
);

  localparam logic [MUL_CNT_W-1:0] LAST_CNT = MUL_CNT_W'(MUL_CYCLES - 1);

  mul_state_e           state_q, state_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]          mcand_q, mcand_d;
  logic [63:0]          mplier_q, mplier_d;
  logic [63:0]          prod_q, prod_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          mcand_d  = a_i;
          mplier_d = b_i;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = MUL_DONE;
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
    // A flushed multiply is simply forgotten; the next start reloads everything.
    if (abort_i) begin
      state_d = MUL_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign idle_o    = (state_q == MUL_IDLE);
  assign busy_o    = (state_q == MUL_BUSY);
  assign done_o    = (state_q == MUL_DONE);
  assign product_o = prod_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, branch resolve, multiplier control, EX/MEM register
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] id_ex_pc_out,
  input  logic [XLEN-1:0] id_ex_read_data1,
  input  logic [XLEN-1:0] id_ex_read_data2,
  input  logic [XLEN-1:0] id_ex_immGen,
  input  logic [4:0]      id_ex_rd,
  input  logic [3:0]      id_ex_funct3,
  input  logic            id_ex_branch,
  input  logic            id_ex_memread,
  input  logic            id_ex_memtoreg,
  input  logic            id_ex_memwrite,
  input  logic            id_ex_regwrite,
  input  logic            id_ex_alusrc,
  input  logic [1:0]      id_ex_aluop,
  input  logic            id_ex_mul,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_write_data,
  output logic [XLEN-1:0] ex_mem_branch_target,
  output logic [4:0]      ex_mem_rd,
  output logic            ex_mem_branch_taken,
  output logic            ex_mem_memread,
  output logic            ex_mem_memtoreg,
  output logic            ex_mem_memwrite,
  output logic            ex_mem_regwrite
);

  logic [XLEN-1:0] op_a, op_b, alu_res, result_d;
  logic [5:0]      shamt;
  alu_op_e         alu_op;
  logic            cond, taken_d;
  logic            mul_idle, mul_busy, mul_done;
  logic [XLEN-1:0] mul_product;

  assign op_a   = id_ex_read_data1;
  assign op_b   = id_ex_alusrc ? id_ex_immGen : id_ex_read_data2;
  assign shamt  = op_b[5:0];
  assign alu_op = alu_decode(id_ex_aluop, id_ex_funct3, id_ex_alusrc);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_SLL: alu_res = op_a << shamt;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SRL: alu_res = op_a >> shamt;
      ALU_SRA: alu_res = $signed(op_a) >>> shamt;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_AND: alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (id_ex_funct3[2:0])
      3'b000:  cond = (op_a == op_b);
      3'b001:  cond = (op_a != op_b);
      3'b100:  cond = ($signed(op_a) < $signed(op_b));
      3'b101:  cond = ($signed(op_a) >= $signed(op_b));
      3'b110:  cond = (op_a < op_b);
      3'b111:  cond = (op_a >= op_b);
      default: cond = 1'b0;
    endcase
  end

  assign taken_d = id_ex_branch & cond;

  // MUL takes rs2 directly; the immediate mux does not apply to it.
  mul_iter u_mul (
    .clk_i     (clk),
    .reset_i   (reset),
    .abort_i   (flush),
    .start_i   (id_ex_mul),
    .a_i       (id_ex_read_data1),
    .b_i       (id_ex_read_data2),
    .idle_o    (mul_idle),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign stall    = (mul_idle & id_ex_mul) | mul_busy;
  assign result_d = (id_ex_mul & mul_done) ? mul_product : alu_res;

  always_ff @(posedge clk) begin
    if (reset || flush || stall) begin
      ex_mem_alu_result    <= '0;
      ex_mem_write_data    <= '0;
      ex_mem_branch_target <= '0;
      ex_mem_rd            <= '0;
      ex_mem_branch_taken  <= 1'b0;
      ex_mem_memread       <= 1'b0;
      ex_mem_memtoreg      <= 1'b0;
      ex_mem_memwrite      <= 1'b0;
      ex_mem_regwrite      <= 1'b0;
    end else begin
      ex_mem_alu_result    <= result_d;
      ex_mem_write_data    <= id_ex_read_data2;
      ex_mem_branch_target <= id_ex_pc_out + id_ex_immGen;
      ex_mem_rd            <= id_ex_rd;
      ex_mem_branch_taken  <= taken_d;
      ex_mem_memread       <= id_ex_memread;
      ex_mem_memtoreg      <= id_ex_memtoreg;
      ex_mem_memwrite      <= id_ex_memwrite;
      ex_mem_regwrite      <= id_ex_regwrite;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for the execute stage
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc, rd1, rd2, imm;
  logic [4:0]  rd;
  logic [3:0]  f3;
  logic        branch, memread, memtoreg, memwrite, regwrite, alusrc;
  logic [1:0]  aluop;
  logic        mul, flush;
  logic        stall;
  logic [63:0] o_res, o_wdata, o_tgt;
  logic [4:0]  o_rd;
  logic        o_taken, o_memread, o_memtoreg, o_memwrite, o_regwrite;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .id_ex_pc_out(pc), .id_ex_read_data1(rd1), .id_ex_read_data2(rd2), .id_ex_immGen(imm),
    .id_ex_rd(rd), .id_ex_funct3(f3),
    .id_ex_branch(branch), .id_ex_memread(memread), .id_ex_memtoreg(memtoreg),
    .id_ex_memwrite(memwrite), .id_ex_regwrite(regwrite), .id_ex_alusrc(alusrc),
    .id_ex_aluop(aluop), .id_ex_mul(mul), .flush(flush), .stall(stall),
    .ex_mem_alu_result(o_res), .ex_mem_write_data(o_wdata), .ex_mem_branch_target(o_tgt),
    .ex_mem_rd(o_rd), .ex_mem_branch_taken(o_taken), .ex_mem_memread(o_memread),
    .ex_mem_memtoreg(o_memtoreg), .ex_mem_memwrite(o_memwrite), .ex_mem_regwrite(o_regwrite)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [3:0] fn,
                                             input logic src, input logic [63:0] a,
                                             input logic [63:0] r2, input logic [63:0] im);
    logic [63:0] b;
    int sh;
    b  = src ? im : r2;
    sh = int'(b % 64);
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return 64'd0;
    case (fn)
      4'h0: return a + b;
      4'h8: return src ? a + b : a - b;
      4'h1: return a << sh;
      4'h4: return a ^ b;
      4'h5: return a >> sh;
      4'hd: return $unsigned($signed(a) >>> sh);
      4'h6: return a | b;
      4'h7: return a & b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic br, input logic [2:0] fn,
                                     input logic [63:0] a, input logic [63:0] b);
    if (!br) return 1'b0;
    case (fn)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_inputs();
    pc = 0; rd1 = 0; rd2 = 0; imm = 0; rd = 0; f3 = 0;
    branch = 0; memread = 0; memtoreg = 0; memwrite = 0; regwrite = 0; alusrc = 0;
    aluop = 0; mul = 0; flush = 0;
  endtask

  // Issues one MUL and follows it through its stall window to the EX/MEM result.
  task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input string tag);
    int cnt;
    logic [63:0] expect_p;
    expect_p = a * b;
    mul = 1; rd1 = a; rd2 = b; imm = 64'd999; alusrc = 1;
    aluop = 2'b10; f3 = 4'h0; regwrite = 1; rd = 5'd9; branch = 0;
    #1;
    chk({tag, " stall at issue"}, 64'(stall), 64'd1);
    cnt = 0;
    while (stall && cnt < 200) begin
      cnt++;
      step();
      chk({tag, " bubble regwrite"}, 64'(o_regwrite), 64'd0);
    end
    chk({tag, " stall length"}, 64'(cnt), 64'd65);
    step();
    chk({tag, " product"}, o_res, expect_p);
    chk({tag, " regwrite"}, 64'(o_regwrite), 64'd1);
  endtask

  typedef struct {
    logic [1:0]  aluop;
    logic [3:0]  f3;
    logic        alusrc;
    logic        branch;
    logic [63:0] a, b2, imm, pc;
    logic [63:0] exp_res;
    logic        exp_taken;
    logic [63:0] exp_tgt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b10, 4'h0, 1'b0, 1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'd0, 64'd2, 1'b0, 64'd0};
    vecs[1]  = '{2'b01, 4'h4, 1'b0, 1'b1, '1, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hF8};
    vecs[2]  = '{2'b01, 4'h6, 1'b0, 1'b1, '1, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'hF8};
    vecs[3]  = '{2'b10, 4'hd, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd0, 64'hF800_0000_0000_0000, 1'b0, 64'd0};
    vecs[4]  = '{2'b10, 4'h1, 1'b1, 1'b0, 64'd1, 64'd0, 64'd63, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 64'd63};
    vecs[5]  = '{2'b10, 4'h8, 1'b1, 1'b0, 64'd10, 64'd0, 64'd3, 64'd0, 64'd13, 1'b0, 64'd3};
    vecs[6]  = '{2'b10, 4'h8, 1'b0, 1'b0, 64'd10, 64'd3, 64'd0, 64'd0, 64'd7, 1'b0, 64'd0};
    vecs[7]  = '{2'b11, 4'h0, 1'b0, 1'b0, 64'd5, 64'd6, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0};
    vecs[8]  = '{2'b10, 4'h2, 1'b0, 1'b0, 64'd5, 64'd6, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0};
    vecs[9]  = '{2'b01, 4'h5, 1'b0, 1'b1, '1, 64'd1, 64'd0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h40};
    vecs[10] = '{2'b01, 4'h0, 1'b0, 1'b1, 64'd7, 64'd7, 64'd16, 64'h40, 64'd0, 1'b1, 64'h50};
    vecs[11] = '{2'b10, 4'h5, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h44, 64'd0, 64'd0, 64'h0800_0000_0000_0000, 1'b0, 64'd0};

    clear_inputs();
    reset = 1;
    rd2 = 64'h1234; pc = 64'h55; regwrite = 1; memwrite = 1;
    step();
    step();
    chk("reset alu_result", o_res, 64'd0);
    chk("reset write_data", o_wdata, 64'd0);
    chk("reset target", o_tgt, 64'd0);
    chk("reset regwrite", 64'(o_regwrite), 64'd0);
    chk("reset memwrite", 64'(o_memwrite), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    reset = 0;
    clear_inputs();

    for (int i = 0; i < 12; i++) begin
      aluop = vecs[i].aluop; f3 = vecs[i].f3; alusrc = vecs[i].alusrc; branch = vecs[i].branch;
      rd1 = vecs[i].a; rd2 = vecs[i].b2; imm = vecs[i].imm; pc = vecs[i].pc;
      rd = 5'(i + 1); regwrite = 1;
      step();
      chk($sformatf("vec%0d result", i), o_res, vecs[i].exp_res);
      chk($sformatf("vec%0d taken", i), 64'(o_taken), 64'(vecs[i].exp_taken));
      chk($sformatf("vec%0d target", i), o_tgt, vecs[i].exp_tgt);
      chk($sformatf("vec%0d wdata", i), o_wdata, vecs[i].b2);
      chk($sformatf("vec%0d rd", i), 64'(o_rd), 64'(i + 1));
    end

    for (int i = 0; i < 200; i++) begin
      logic [63:0] bsel;
      aluop = 2'($urandom); f3 = 4'($urandom); alusrc = 1'($urandom); branch = 1'($urandom);
      rd1 = {$urandom, $urandom}; rd2 = {$urandom, $urandom}; imm = {$urandom, $urandom};
      pc = {$urandom, $urandom}; rd = 5'($urandom);
      regwrite = 1'($urandom); memread = 1'($urandom); memwrite = 1'($urandom); memtoreg = 1'($urandom);
      if (i % 4 == 0) rd2 = rd1;
      bsel = alusrc ? imm : rd2;
      step();
      chk("rand result", o_res, ref_result(aluop, f3, alusrc, rd1, rd2, imm));
      chk("rand taken", 64'(o_taken), 64'(ref_taken(branch, f3[2:0], rd1, bsel)));
      chk("rand target", o_tgt, pc + imm);
      chk("rand ctrl", {60'd0, o_regwrite, o_memread, o_memwrite, o_memtoreg},
          {60'd0, regwrite, memread, memwrite, memtoreg});
    end
    clear_inputs();

    run_mul(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul 7x-3");
    run_mul(64'd3, 64'd4, "mul 3x4");
    run_mul(64'd5, 64'd6, "mul 5x6");
    clear_inputs();
    step();

    rd1 = 64'd9; rd2 = 64'd9; mul = 1; regwrite = 1; aluop = 2'b10;
    for (int i = 0; i < 21; i++) step();
    flush = 1;
    step();
    flush = 0; mul = 0;
    rd1 = 64'd20; rd2 = 64'd22; alusrc = 0; f3 = 4'h0; regwrite = 1;
    chk("flush bubble regwrite", 64'(o_regwrite), 64'd0);
    chk("flush bubble result", o_res, 64'd0);
    #1;
    chk("flush stall drop", 64'(stall), 64'd0);
    step();
    chk("post-flush add", o_res, 64'd42);
    chk("post-flush regwrite", 64'(o_regwrite), 64'd1);

    rd1 = 64'd11; rd2 = 64'd13; mul = 1; pc = 64'h77; imm = 64'h8;
    for (int i = 0; i < 31; i++) step();
    reset = 1;
    step();
    reset = 0; mul = 0;
    chk("mid-mul reset result", o_res, 64'd0);
    chk("mid-mul reset wdata", o_wdata, 64'd0);
    chk("mid-mul reset target", o_tgt, 64'd0);
    chk("mid-mul reset regwrite", 64'(o_regwrite), 64'd0);
    #1;
    chk("mid-mul reset stall", 64'(stall), 64'd0);
    run_mul(64'd11, 64'd13, "mul after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
